axis_pkt_gen: RTL and testbench
===============================

// Module: axis_pkt_gen
// PURPOSE
//  AXI4-Stream packet source that feeds the s00_axis slave port of axis_fifo.
//  On a start pulse it emits a programmed number of packets of programmed beat length.
//  Packets carry an incrementing data pattern with tlast on the final beat, and optional idle gaps between packets.
//  Used as the traffic stage ahead of the FIFO in lab designs and benches.
// PARAMETERS
//  C_AXIS_TDATA_WIDTH  32  data width in bits, multiple of 8
//  LEN_WIDTH           12  width of pkt_len (beats per packet)
//  CNT_WIDTH           16  width of num_pkts, pkt_count, gap_cycles
// PORTS
//  m00_axis_aclk     in   1      single clock, rising edge
//  m00_axis_aresetn  in   1      asynchronous active-low reset
//  start             in   1      1-cycle pulse; sampled only in IDLE
//  stop              in   1      level; finish current packet, then DONE
//  pkt_len           in   LEN_WIDTH  beats per packet, sampled at start
//  num_pkts          in   CNT_WIDTH  packets to send, sampled at start
//  gap_cycles        in   CNT_WIDTH  idle cycles between packets, sampled at start
//  seed              in   C_AXIS_TDATA_WIDTH  first data word, sampled at start
//  m00_axis_tdata    out  C_AXIS_TDATA_WIDTH  stream data
//  m00_axis_tstrb    out  C_AXIS_TDATA_WIDTH/8  byte strobes, all ones while tvalid=1
//  m00_axis_tvalid   out  1      data valid
//  m00_axis_tready   in   1      downstream ready (FIFO s00_axis_tready)
//  m00_axis_tlast    out  1      last beat of packet
//  busy              out  1      high in SEND/GAP
//  done              out  1      1-cycle pulse when the run ends
//  pkt_count         out  CNT_WIDTH  packets fully sent in the current/last run
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0. Takes effect immediately and asynchronously.
//  Reset mid-packet: tvalid drops at once, and the partial packet is abandoned.
//  FSM states IDLE, SEND, GAP, DONE. All outputs are registered.
//  IDLE: on start=1, latch inputs, clear pkt_count and data word := seed.
//    If num_pkts==0, go to DONE. Otherwise go to SEND.
//    tvalid rises on the edge after start is sampled (1-cycle latency).
//  pkt_len==0 is treated as 1 beat.
//  SEND: tvalid=1, tdata=current word. tlast=1 when beat index == len-1.
//    Beat completes when tvalid&&tready. On completion: word := word+1 (mod 2^C_AXIS_TDATA_WIDTH), beat index +1.
//    While tready=0, tdata/tlast/tvalid hold stable. tvalid never drops without a handshake.
//  Last beat accepted: pkt_count+1, beat index := 0. Next state:
//    DONE if pkt_count+1==num_pkts or stop=1;
//    else GAP if gap_cycles>0;
//    else SEND. Back-to-back packets need no dead cycle.
//  GAP: tvalid=0 for exactly gap_cycles cycles, then SEND. stop=1 in GAP -> DONE next cycle.
//  stop in SEND never truncates a packet. It is evaluated only at last-beat acceptance.
//  DONE: done=1 for one cycle, then IDLE. pkt_count holds until the next start.
//  start outside IDLE is ignored. The word counter wraps silently, and the pattern continues across packets.
//  busy=1 exactly when state is SEND or GAP.
// TESTING
//  1) len=4, num=2, gap=0, seed=5, tready=1 -> 8 contiguous beats of data 5..12.
//     tlast on data 8 and 12; pkt_count=2; done pulses 1 cycle after data 12 is accepted.
//  2) len=3, num=1, seed=10; tready=0 for 20 cycles, then 1.
//     -> tvalid=1 and tdata=10 held stable for all 20 cycles; then 10, 11, 12(tlast).
//  3) len=2, num=3, gap=3, tready=1 -> exactly 3 tvalid-low cycles between packets.
//     busy stays 1 throughout; done pulses after the 6th beat.
//  4) len=5, num=10; stop raised during the 2nd beat of packet 2.
//     -> packet 2 completes with all 5 beats and tlast; then done; pkt_count=2.
//  5) Assert aresetn=0 mid-packet (beat 3 of 8) -> tvalid=0 asynchronously, pkt_count=0, IDLE.
//     A new start then begins again from seed.
//  6) num=0 -> no tvalid, done pulses once. len=0 -> 1-beat packets, tlast on every beat.
//     seed=32'hFFFFFFFE, len=4 -> data FFFFFFFE, FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: on start, emits num_pkts packets of pkt_len beats carrying an
// incrementing data word, with tlast on each final beat and optional idle gaps between packets.
module axis_pkt_gen #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH          = 12,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                            m00_axis_aclk,
    input  logic                            m00_axis_aresetn,
    input  logic                            start,
    input  logic                            stop,
    input  logic [LEN_WIDTH-1:0]            pkt_len,
    input  logic [CNT_WIDTH-1:0]            num_pkts,
    input  logic [CNT_WIDTH-1:0]            gap_cycles,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   seed,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                            m00_axis_tvalid,
    input  logic                            m00_axis_tready,
    output logic                            m00_axis_tlast,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_WIDTH-1:0]            pkt_count
);

    localparam int unsigned StrbWidth = C_AXIS_TDATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0]          LenOne  = 1;
    localparam logic [CNT_WIDTH-1:0]          CntOne  = 1;
    localparam logic [C_AXIS_TDATA_WIDTH-1:0] WordOne = 1;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e                          state_q, state_d;
    logic [LEN_WIDTH-1:0]            len_last_q, len_last_d;
    logic [LEN_WIDTH-1:0]            beat_q, beat_d;
    logic [CNT_WIDTH-1:0]            num_q, num_d;
    logic [CNT_WIDTH-1:0]            gap_q, gap_d;
    logic [CNT_WIDTH-1:0]            gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]            pkt_count_q, pkt_count_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]   word_q, word_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [CNT_WIDTH-1:0]            pkt_inc;
    logic                            handshake;

    always_comb begin
        state_d     = state_q;
        len_last_d  = len_last_q;
        beat_d      = beat_q;
        num_d       = num_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_count_d = pkt_count_q;
        word_d      = word_q;
        pkt_inc     = pkt_count_q + CntOne;
        handshake   = tvalid_q && m00_axis_tready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Store the index of the last beat; a zero length still sends one beat.
                    len_last_d  = (pkt_len == '0) ? '0 : pkt_len - LenOne;
                    num_d       = num_pkts;
                    gap_d       = gap_cycles;
                    word_d      = seed;
                    beat_d      = '0;
                    pkt_count_d = '0;
                    state_d     = (num_pkts == '0) ? StDone : StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    word_d = word_q + WordOne;
                    if (beat_q == len_last_q) begin
                        pkt_count_d = pkt_inc;
                        beat_d      = '0;
                        if (pkt_inc == num_q || stop) begin
                            state_d = StDone;
                        end else if (gap_q != '0) begin
                            state_d   = StGap;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + LenOne;
                    end
                end
            end
            StGap: begin
                if (stop) begin
                    state_d = StDone;
                end else if (gap_cnt_q <= CntOne) begin
                    state_d = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - CntOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from next-state values so they register alongside the state.
        tvalid_d = (state_d == StSend);
        tlast_d  = tvalid_d && (beat_d == len_last_d);
        busy_d   = (state_d == StSend) || (state_d == StGap);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q     <= StIdle;
            len_last_q  <= '0;
            beat_q      <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
            word_q      <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_last_q  <= len_last_d;
            beat_q      <= beat_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_count_q <= pkt_count_d;
            word_q      <= word_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m00_axis_tdata  = tvalid_q ? word_q : '0;
    assign m00_axis_tstrb  = {StrbWidth{tvalid_q}};
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pkt_count       = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: stimulus pushes expected beats, a forked monitor pops and
// compares on every handshake and also checks stall stability, gaps and done timing.
module tb_axis_pkt_gen;

    localparam int DW = 32;
    localparam int LW = 12;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [LW-1:0]   pkt_len = '0;
    logic [CW-1:0]   num_pkts = '0;
    logic [CW-1:0]   gap_cycles = '0;
    logic [DW-1:0]   seed = '0;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid;
    logic            tready = 1'b1;
    logic            tlast;
    logic            busy;
    logic            done;
    logic [CW-1:0]   pkt_count;

    axis_pkt_gen #(
        .C_AXIS_TDATA_WIDTH(DW),
        .LEN_WIDTH         (LW),
        .CNT_WIDTH         (CW)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(rst_n),
        .start           (start),
        .stop            (stop),
        .pkt_len         (pkt_len),
        .num_pkts        (num_pkts),
        .gap_cycles      (gap_cycles),
        .seed            (seed),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tready (tready),
        .m00_axis_tlast  (tlast),
        .busy            (busy),
        .done            (done),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    typedef logic [DW:0] beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int done_cnt = 0;
    int done_at = 0;
    int stall_cnt = 0;
    int gap_low = 0;
    int nobusy = 0;
    bit in_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        beat_t         e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
                in_run     = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", {63'd0, tvalid}, 64'd1);
                    chk("hold_data", {32'd0, tdata}, {32'd0, pd});
                    chk("hold_last", {63'd0, tlast}, {63'd0, pl});
                end
                if (tvalid) begin
                    in_run = 1;
                    chk("tstrb", {60'd0, tstrb}, 64'hF);
                    if (tready) begin
                        acc_cnt++;
                        last_acc = ncyc;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat: got data %0h, scoreboard empty", tdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", {32'd0, tdata}, {32'd0, e[DW-1:0]});
                            chk("beat_last", {63'd0, tlast}, {63'd0, e[DW]});
                        end
                    end
                end
                if (tvalid && !tready) stall_cnt++;
                if (busy && !tvalid) gap_low++;
                if (in_run && !busy && !done) nobusy++;
                if (done) begin
                    done_cnt++;
                    done_at = ncyc;
                    in_run  = 0;
                end
                prev_stall = tvalid && !tready;
                pd = tdata;
                pl = tlast;
            end
        end
    endtask

    task automatic push(input logic [DW-1:0] sd, input int len, input int n);
        logic [DW-1:0] w = sd;
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < len; b++) begin
                exp_q.push_back({(b == len - 1), w});
                w = w + 1;
            end
        end
    endtask

    task automatic pulse_start(input int len, input int num, input int gap, input logic [DW-1:0] sd);
        @(posedge clk);
        #1;
        pkt_len    = LW'(len);
        num_pkts   = CW'(num);
        gap_cycles = CW'(gap);
        seed       = sd;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit chk_lat);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt - base), 64'd1);
        if (chk_lat) chk({name, "_done_latency"}, 64'(done_at - last_acc), 64'd1);
        @(negedge clk);
        #1;
        chk({name, "_done_pulse"}, 64'(done_cnt - base), 64'd1);
        chk({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_acc(input string name, input int base, input int target);
        int n = 0;
        while (acc_cnt - base < target && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_acc_reached"}, 64'(acc_cnt - base), 64'(target));
    endtask

    initial begin
        int b_stall, b_gap, b_nob, b_acc;
        fork
            monitor();
        join_none

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, tlast}, 64'd0);
        chk("rst_tdata", {32'd0, tdata}, 64'd0);
        chk("rst_tstrb", {60'd0, tstrb}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        rst_n = 1'b1;

        // Two back-to-back packets, no gap.
        push(32'd5, 4, 2);
        b_gap = gap_low;
        pulse_start(4, 2, 0, 32'd5);
        wait_done("t1", 1);
        chk("t1_pkt_count", {48'd0, pkt_count}, 64'd2);
        chk("t1_contiguous", 64'(gap_low - b_gap), 64'd0);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure for 20 cycles from the first valid beat.
        tready = 1'b0;
        push(32'd10, 3, 1);
        b_stall = stall_cnt;
        pulse_start(3, 1, 0, 32'd10);
        repeat (20) @(posedge clk);
        #1;
        tready = 1'b1;
        wait_done("t2", 1);
        chk("t2_stall_cycles", 64'(stall_cnt - b_stall), 64'd20);
        chk("t2_pkt_count", {48'd0, pkt_count}, 64'd1);

        // Three packets with 3-cycle gaps.
        push(32'h100, 2, 3);
        b_gap = gap_low;
        b_nob = nobusy;
        pulse_start(2, 3, 3, 32'h100);
        wait_done("t3", 1);
        chk("t3_gap_low_cycles", 64'(gap_low - b_gap), 64'd6);
        chk("t3_busy_held", 64'(nobusy - b_nob), 64'd0);
        chk("t3_pkt_count", {48'd0, pkt_count}, 64'd3);

        // Stop raised during the second beat of packet 2.
        push(32'h200, 5, 2);
        b_acc = acc_cnt;
        pulse_start(5, 10, 0, 32'h200);
        wait_acc("t4", b_acc, 6);
        stop = 1'b1;
        wait_done("t4", 1);
        stop = 1'b0;
        chk("t4_pkt_count", {48'd0, pkt_count}, 64'd2);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while beat 3 of 8 is presented.
        push(32'h300, 2, 1);
        exp_q[exp_q.size() - 1][DW] = 1'b0;
        b_acc = acc_cnt;
        pulse_start(8, 1, 0, 32'h300);
        wait_acc("t5", b_acc, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t5_async_busy", {63'd0, busy}, 64'd0);
        chk("t5_async_pkt_count", {48'd0, pkt_count}, 64'd0);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'h300, 2, 1);
        pulse_start(2, 1, 0, 32'h300);
        wait_done("t5r", 1);
        chk("t5r_pkt_count", {48'd0, pkt_count}, 64'd1);

        // Zero packets: no beats, a single done pulse.
        b_acc = acc_cnt;
        pulse_start(4, 0, 0, 32'd7);
        wait_done("t6a", 0);
        chk("t6a_no_beats", 64'(acc_cnt - b_acc), 64'd0);
        chk("t6a_pkt_count", {48'd0, pkt_count}, 64'd0);

        // Zero length behaves as single-beat packets.
        push(32'h40, 1, 3);
        pulse_start(0, 3, 0, 32'h40);
        wait_done("t6b", 1);
        chk("t6b_pkt_count", {48'd0, pkt_count}, 64'd3);

        // Data word wraps through zero.
        push(32'hFFFF_FFFE, 4, 1);
        pulse_start(4, 1, 0, 32'hFFFF_FFFE);
        wait_done("t6c", 1);
        chk("t6c_pkt_count", {48'd0, pkt_count}, 64'd1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
